// File: rtl/spi_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl_if
// Groups the host request/response handshake and the SPI bus pins of the
// spi_master_ctrl block.
//   Host side : start, cmd[1:0], tx_data[DATA_W-1:0]  -> master
//               busy, done, rx_data[DATA_W-1:0], rx_valid <- master
//   SPI side  : SS_n, MOSI                             <- master
//               MISO                                   -> master
// Modports:
//   master : the SPI master controller itself
//   slave  : whatever drives requests and models the SPI slave (host + slave)
// -----------------------------------------------------------------------------
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  start, cmd, tx_data, MISO,
        output busy, done, rx_data, rx_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, tx_data, MISO,
        input  busy, done, rx_data, rx_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Single-clock SPI master. One host request produces one SPI frame:
//   SS_n low, LEAD_CYC idle cycles, 11 MOSI bits {cmd[1], cmd[1:0], tx_data}
//   MSB first, then (read-data only) READ_LAT turnaround cycles and DATA_W
//   MISO samples, then SS_n high for GAP_CYC cycles before done is reported.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_ctrl_if.master
//          start/cmd/tx_data  request (accepted only while busy=0)
//          busy/done          transaction status, done is a 1-cycle pulse
//          rx_data/rx_valid   read-data result, rx_valid pulses with done
//          SS_n/MOSI/MISO     SPI pins
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int DATA_W   = 8,
    parameter int LEAD_CYC = 1,
    parameter int READ_LAT = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_master_ctrl_if.master        bus
);
    localparam int FRAME_W = DATA_W + 3;
    localparam int MAX_A   = (LEAD_CYC > FRAME_W) ? LEAD_CYC : FRAME_W;
    localparam int MAX_B   = (READ_LAT > MAX_A) ? READ_LAT : MAX_A;
    localparam int MAX_CNT = (GAP_CYC > MAX_B) ? GAP_CYC : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT_OUT,
        S_WAIT_RD,
        S_SHIFT_IN,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [FRAME_W-1:0]   r_tx_sr;
    logic [FRAME_W-1:0]   w_tx_sr_nxt;
    logic [DATA_W-1:0]    r_rx_sr;
    logic [DATA_W-1:0]    w_rx_sr_nxt;
    logic                 r_is_rd;
    logic                 w_is_rd_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_rx_valid;
    logic                 w_rx_valid_nxt;
    logic [DATA_W-1:0]    r_rx_data;
    logic [DATA_W-1:0]    w_rx_data_nxt;
    logic                 r_ss_n;
    logic                 w_ss_n_nxt;
    logic                 r_mosi;
    logic                 w_mosi_nxt;

    // State and registered outputs. Reset returns SS_n high immediately so an
    // interrupted frame is visibly abandoned by the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_is_rd    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_is_rd    <= w_is_rd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_ss_n     <= w_ss_n_nxt;
            r_mosi     <= w_mosi_nxt;
        end
    end

    // Next-state and next-output logic. r_cnt is loaded with (length-1) when a
    // phase is entered and the phase ends on the cycle it reads zero.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_is_rd_nxt    = r_is_rd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_rx_valid_nxt = 1'b0;
        w_rx_data_nxt  = r_rx_data;
        w_ss_n_nxt     = r_ss_n;
        w_mosi_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LEAD;
                    w_cnt_nxt   = CNT_W'(LEAD_CYC - 1);
                    // Leading bit duplicates cmd[1] as the slave's rw-select.
                    w_tx_sr_nxt = {bus.cmd[1], bus.cmd, bus.tx_data};
                    w_is_rd_nxt = (bus.cmd == 2'b11);
                    w_busy_nxt  = 1'b1;
                    w_ss_n_nxt  = 1'b0;
                end
            end

            S_LEAD: begin
                if (r_cnt == '0) begin
                    // MOSI is registered, so the first frame bit is launched
                    // on the edge that enters SHIFT_OUT.
                    w_state_nxt = S_SHIFT_OUT;
                    w_cnt_nxt   = CNT_W'(FRAME_W - 1);
                    w_mosi_nxt  = r_tx_sr[FRAME_W-1];
                    w_tx_sr_nxt = {r_tx_sr[FRAME_W-2:0], 1'b0};
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_SHIFT_OUT: begin
                if (r_cnt == '0) begin
                    if (!r_is_rd) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = CNT_W'(GAP_CYC - 1);
                        w_ss_n_nxt  = 1'b1;
                    end else if (READ_LAT == 0) begin
                        w_state_nxt = S_SHIFT_IN;
                        w_cnt_nxt   = CNT_W'(DATA_W - 1);
                    end else begin
                        w_state_nxt = S_WAIT_RD;
                        w_cnt_nxt   = CNT_W'(READ_LAT - 1);
                    end
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_mosi_nxt  = r_tx_sr[FRAME_W-1];
                    w_tx_sr_nxt = {r_tx_sr[FRAME_W-2:0], 1'b0};
                end
            end

            S_WAIT_RD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SHIFT_IN;
                    w_cnt_nxt   = CNT_W'(DATA_W - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_SHIFT_IN: begin
                // Only place MISO is looked at; garbage elsewhere never reaches
                // the receive register.
                w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], bus.MISO};
                if (r_cnt == '0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = CNT_W'(GAP_CYC - 1);
                    w_ss_n_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    if (r_is_rd) begin
                        w_rx_data_nxt  = r_rx_sr;
                        w_rx_valid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_ss_n_nxt  = 1'b1;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;

endmodule
